vde_streamer: RTL

Video data engine occupying bus region `addr[31:29] == 3'b100`. It accepts pixels and solid-colour fill commands from the CPU over the shared memory bus, buffers them, and drives the 24-bit pixel stream consumed by the display back-end through a valid/ready handshake. It also exposes the display's frame index and a frame-change flag so software can pace rendering.

---
 rtl/vde_streamer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vde_streamer.sv
// vde_streamer
// Video data engine on the shared memory bus. The CPU pushes RGB888 pixels
// into a FIFO or arms solid-colour fills, and the engine streams them to the
// display back-end over a valid/ready handshake. It also reports the display
// frame index and a sticky frame-change flag for render pacing.
//
// Ports:
//   clk_i, rstn_i        system clock, asynchronous active-low reset
//   enable_i, wstrb_i    bus strobe (region already decoded), byte write strobes
//   addr_i               current address, addr_i[4:2] selects the write target
//   addr_prev_i          previous-cycle address, addr_prev_i[4:2] selects rvalue_o
//   wvalue_i, rvalue_o   write data, combinational read data
//   pixel_valid_o/ready  output pixel handshake, pixel_data_o is RGB888
//   frame_idx_i          display frame index, synchronous to clk_i
module vde_streamer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        enable_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] addr_prev_i,
  input  logic [31:0] wvalue_i,
  output logic [31:0] rvalue_o,
  input  logic        pixel_ready_i,
  output logic        pixel_valid_o,
  output logic [23:0] pixel_data_o,
  input  logic        frame_idx_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FIFO, S_FILL} state_t;

  state_t        state, state_next;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [23:0]   fill_color;
  logic [19:0]   fill_remain;
  logic          ovf, frame_chg, frame_prev;

  logic          wr_en, push_req, push, pop, fill_load, load_en;
  logic          fifo_full, fifo_empty, fill_busy, fill_last;
  logic          src_valid;
  logic [23:0]   src_data;
  logic [2:0]    wsel;
  logic [4:0]    count_field;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign wr_en      = enable_i && (wstrb_i != 4'd0);
  assign wsel       = addr_i[4:2];
  assign push_req   = wr_en && (wsel == 3'd0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  // A full FIFO drops the push even if a pop frees a slot this same cycle.
  assign push       = push_req && !fifo_full;
  // Remaining count doubles as the armed/active flag: nonzero means busy.
  assign fill_busy  = (fill_remain != 20'd0);
  assign fill_last  = fill_load && (fill_remain == 20'd1);
  assign load_en    = !pixel_valid_o || pixel_ready_i;

  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], addr_prev_i[31:5],
                         addr_prev_i[1:0], wvalue_i[31:24], wstrb_i[3]};

  // FIFO storage has no reset; only pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wvalue_i[23:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Fill colour (per-byte writes) and fill pixel countdown.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fill_color  <= '0;
      fill_remain <= '0;
    end else begin
      if (wr_en && wsel == 3'd1) begin
        for (int b = 0; b < 3; b++) begin
          if (wstrb_i[b]) fill_color[8*b +: 8] <= wvalue_i[8*b +: 8];
        end
      end
      if (fill_load) begin
        fill_remain <= fill_remain - 20'd1;
      end else if (wr_en && wsel == 3'd2 && !fill_busy) begin
        fill_remain <= wvalue_i[19:0];
      end
    end
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf        <= 1'b0;
      frame_chg  <= 1'b0;
      frame_prev <= 1'b0;
    end else begin
      frame_prev <= frame_idx_i;
      if (push_req && fifo_full)
        ovf <= 1'b1;
      else if (wr_en && wsel == 3'd3 && wstrb_i[0] && wvalue_i[3])
        ovf <= 1'b0;
      if (frame_idx_i != frame_prev)
        frame_chg <= 1'b1;
      else if (wr_en && wsel == 3'd3 && wstrb_i[1] && wvalue_i[10])
        frame_chg <= 1'b0;
    end
  end

  // Source FSM: state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= S_IDLE;
    else         state <= state_next;
  end

  // Source FSM: next state. IDLE checks the FIFO first so it always drains
  // before an armed fill starts.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty)    state_next = S_FIFO;
        else if (fill_busy) state_next = fill_last ? S_IDLE : S_FILL;
      end
      S_FIFO: begin
        if (fifo_empty) state_next = S_IDLE;
      end
      S_FILL: begin
        if (!fill_busy || fill_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Source FSM: outputs. IDLE already offers data so a push reaches the
  // output register without an extra state-change cycle.
  always_comb begin
    src_valid = 1'b0;
    src_data  = mem[rd_ptr];
    pop       = 1'b0;
    fill_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          src_valid = 1'b1;
          pop       = load_en;
        end else if (fill_busy) begin
          src_valid = 1'b1;
          src_data  = fill_color;
          fill_load = load_en;
        end
      end
      S_FIFO: begin
        if (!fifo_empty) begin
          src_valid = 1'b1;
          pop       = load_en;
        end
      end
      S_FILL: begin
        if (fill_busy) begin
          src_valid = 1'b1;
          src_data  = fill_color;
          fill_load = load_en;
        end
      end
      default: ;
    endcase
  end

  // Output register; data is held whenever the sink stalls a valid pixel.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pixel_valid_o <= 1'b0;
      pixel_data_o  <= '0;
    end else if (load_en) begin
      pixel_valid_o <= src_valid;
      if (src_valid) pixel_data_o <= src_data;
    end
  end

  assign count_field = 5'(fifo_count);
  assign status_word = {21'd0, frame_chg, frame_idx_i, count_field,
                        ovf, fill_busy, fifo_full, fifo_empty};

  // Read mux keyed by the previous-cycle address, showing live contents.
  always_comb begin
    rvalue_o = 32'd0;
    case (addr_prev_i[4:2])
      3'd1:    rvalue_o = {8'd0, fill_color};
      3'd3:    rvalue_o = status_word;
      3'd4:    rvalue_o = {12'd0, fill_remain};
      default: rvalue_o = 32'd0;
    endcase
  end

endmodule
